// File: rtl/hazard_npc_unit.sv
// rtl/hazard_npc_unit.sv - load-use/redirect/memory-wait hazard control and next-PC select
// Outputs are combinational from state and inputs; only the FSM state and event counters are registered.
module hazard_npc_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_target,
    input  logic             mem_busy,
    output logic [31:0]      npc,
    output logic             data_hazard,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              lu_hit;

    assign lu_hit = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

    // MEM_WAIT without mem_busy falls through to the RUN rules in the same cycle.
    always_comb begin
        state_d     = RUN;
        npc         = pc + 32'd4;
        data_hazard = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        if (rst) begin
            state_d = RUN;
        end else if (mem_busy) begin
            data_hazard = 1'b1;
            npc         = pc;
            state_d     = MEM_WAIT;
        end else if (ex_redirect) begin
            npc        = ex_target & 32'hFFFF_FFFC;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (lu_hit && (state_q != LU_BUBBLE)) begin
            data_hazard = 1'b1;
            npc         = pc;
            flush_idex  = 1'b1;
            state_d     = LU_BUBBLE;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (data_hazard && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_ifid && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_npc_unit.sv
// tb/tb_hazard_npc_unit.sv - directed self-checking bench for hazard_npc_unit
// Uses a 4-bit counter width so saturation is reached in a few cycles.
module tb_hazard_npc_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   pc;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect, mem_busy;
    logic [31:0]   ex_target;
    logic [31:0]   npc;
    logic          data_hazard, flush_ifid, flush_idex;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_npc_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect), .ex_target(ex_target),
        .mem_busy(mem_busy), .npc(npc), .data_hazard(data_hazard),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; ex_target = 32'h0; mem_busy = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        pc = 32'h100;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (npc !== 32'h104) begin errors++; $display("FAIL reset_npc got=%h exp=%h", npc, 32'h104); end
        checks++; if ({data_hazard, flush_ifid, flush_idex} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {data_hazard, flush_ifid, flush_idex}); end
        checks++; if ({stall_cnt, flush_cnt} !== 8'h00) begin errors++; $display("FAIL reset_cnt got=%h exp=00", {stall_cnt, flush_cnt}); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (npc !== 32'h104) begin errors++; $display("FAIL idle_npc[%0d] got=%h exp=%h", i, npc, 32'h104); end
            checks++; if ({data_hazard, flush_ifid, flush_idex} !== 3'b000) begin errors++; $display("FAIL idle_flags[%0d] got=%b exp=000", i, {data_hazard, flush_ifid, flush_idex}); end
            checks++; if ({stall_cnt, flush_cnt} !== 8'h00) begin errors++; $display("FAIL idle_cnt[%0d] got=%h exp=00", i, {stall_cnt, flush_cnt}); end
            tick();
        end
    endtask

    task automatic test_load_use();
        set_load_use();
        #1;
        checks++; if ({data_hazard, flush_idex, flush_ifid} !== 3'b110) begin errors++; $display("FAIL lu_c0_flags got=%b exp=110", {data_hazard, flush_idex, flush_ifid}); end
        checks++; if (npc !== 32'h100) begin errors++; $display("FAIL lu_c0_npc got=%h exp=%h", npc, 32'h100); end
        tick();
        checks++; if ({data_hazard, flush_idex} !== 2'b00) begin errors++; $display("FAIL lu_c1_flags got=%b exp=00", {data_hazard, flush_idex}); end
        checks++; if (npc !== 32'h104) begin errors++; $display("FAIL lu_c1_npc got=%h exp=%h", npc, 32'h104); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        clear_inputs();
        tick();
    endtask

    task automatic test_no_stall();
        set_load_use(); ex_rd = 5'd0; id_rs1 = 5'd0;
        #1;
        checks++; if (data_hazard !== 1'b0) begin errors++; $display("FAIL nostall_rd0 got=%b exp=0", data_hazard); end
        set_load_use(); id_rs1_used = 1'b0;
        #1;
        checks++; if (data_hazard !== 1'b0) begin errors++; $display("FAIL nostall_unused got=%b exp=0", data_hazard); end
        id_rs2 = 5'd5; id_rs2_used = 1'b1;
        #1;
        checks++; if (data_hazard !== 1'b1) begin errors++; $display("FAIL rs2_hit got=%b exp=1", data_hazard); end
        clear_inputs();
        #1;
    endtask

    task automatic test_redirect();
        set_load_use();
        ex_redirect = 1'b1; ex_target = 32'h203;
        #1;
        checks++; if (npc !== 32'h200) begin errors++; $display("FAIL redir_npc got=%h exp=%h", npc, 32'h200); end
        checks++; if ({flush_ifid, flush_idex, data_hazard} !== 3'b110) begin errors++; $display("FAIL redir_flags got=%b exp=110", {flush_ifid, flush_idex, data_hazard}); end
        tick();
        clear_inputs();
        #1;
        checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL redir_flush_cnt got=%0d exp=1", flush_cnt); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL redir_stall_cnt got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_mem_busy();
        mem_busy = 1'b1; ex_redirect = 1'b1; ex_target = 32'h300;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({data_hazard, flush_ifid, flush_idex} !== 3'b100) begin errors++; $display("FAIL busy_flags[%0d] got=%b exp=100", i, {data_hazard, flush_ifid, flush_idex}); end
            checks++; if (npc !== 32'h100) begin errors++; $display("FAIL busy_npc[%0d] got=%h exp=%h", i, npc, 32'h100); end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        checks++; if (npc !== 32'h300) begin errors++; $display("FAIL busy_release_npc got=%h exp=%h", npc, 32'h300); end
        checks++; if ({flush_ifid, data_hazard} !== 2'b10) begin errors++; $display("FAIL busy_release_flags got=%b exp=10", {flush_ifid, data_hazard}); end
        checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL busy_stall_cnt got=%0d exp=5", stall_cnt); end
        tick();
        clear_inputs();
        #1;
        checks++; if (flush_cnt !== 4'd2) begin errors++; $display("FAIL busy_flush_cnt got=%0d exp=2", flush_cnt); end
        mem_busy = 1'b1;
        tick();
        mem_busy = 1'b0; set_load_use();
        #1;
        checks++; if (data_hazard !== 1'b1) begin errors++; $display("FAIL memwait_lu got=%b exp=1", data_hazard); end
        clear_inputs();
        #1;
    endtask

    task automatic test_wrap();
        pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (npc !== 32'h0) begin errors++; $display("FAIL wrap_npc got=%h exp=%h", npc, 32'h0); end
        pc = 32'h100;
        #1;
    endtask

    task automatic test_saturate_and_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        #1;
        checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_preload got=%0d exp=14", stall_cnt); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall got=%0d exp=15", stall_cnt); end
        mem_busy = 1'b0; ex_redirect = 1'b1; ex_target = 32'h400;
        for (int i = 0; i < 16; i++) tick();
        checks++; if (flush_cnt !== 4'd15) begin errors++; $display("FAIL sat_flush got=%0d exp=15", flush_cnt); end
        clear_inputs();
        set_load_use();
        tick();
        checks++; if (data_hazard !== 1'b0) begin errors++; $display("FAIL bubble_mask got=%b exp=0", data_hazard); end
        rst = 1'b1;
        #1;
        checks++; if ({data_hazard, flush_ifid, flush_idex} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {data_hazard, flush_ifid, flush_idex}); end
        checks++; if (npc !== 32'h104) begin errors++; $display("FAIL rst_npc got=%h exp=%h", npc, 32'h104); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if ({stall_cnt, flush_cnt} !== 8'h00) begin errors++; $display("FAIL rst_cnt got=%h exp=00", {stall_cnt, flush_cnt}); end
        checks++; if (data_hazard !== 1'b1) begin errors++; $display("FAIL rst_state_run got=%b exp=1", data_hazard); end
        clear_inputs();
        mem_busy = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_busy = 1'b0;
        #1;
        checks++; if ({data_hazard, npc} !== {1'b0, 32'h104}) begin errors++; $display("FAIL rst_memwait got=%h exp=%h", {data_hazard, npc}, {1'b0, 32'h104}); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_memwait_cnt got=%0d exp=0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_mem_busy();
        test_wrap();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_npc_unit.md
HAZARD_NPC_UNIT -- requirements
Module: hazard_npc_unit

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-004 pc  in  32  current fetch address from the PC register.
REQ-005 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-006 id_rs1_used, id_rs2_used  in  1 each  source operand actually read by the ID instruction.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_mem_read  in  1  instruction in EX is a load.
REQ-009 ex_redirect  in  1  taken branch or jump resolved in EX.
REQ-010 ex_target  in  32  redirect target from EX.
REQ-011 mem_busy  in  1  data memory not ready; the whole pipeline freezes.
REQ-012 npc  out  32  next fetch address to the PC register.
REQ-013 data_hazard  out  1  hold PC and IF/ID this cycle.
REQ-014 flush_ifid, flush_idex  out  1 each  insert a bubble into the named pipeline register.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  event counters.

Function
REQ-016 The FSM SHALL have three states: RUN, LU_BUBBLE and MEM_WAIT.
REQ-017 lu_hit SHALL equal ex_mem_read AND ex_rd!=0 AND ((id_rs1_used AND id_rs1==ex_rd) OR (id_rs2_used AND id_rs2==ex_rd)).
REQ-018 Priority SHALL be mem_busy > ex_redirect > lu_hit; all outputs are combinational from state and inputs, with no added latency.
REQ-019 mem_busy=1 (any state): data_hazard=1; both flushes=0; npc=pc; next state MEM_WAIT; ex_redirect and lu_hit are ignored.
REQ-020 MEM_WAIT with mem_busy=0: evaluate as RUN in the same cycle; next state follows the RUN rules.
REQ-021 RUN or LU_BUBBLE with ex_redirect=1: npc={ex_target[31:2],2'b00}; flush_ifid=1; flush_idex=1; data_hazard=0; next state RUN.
REQ-022 RUN with lu_hit=1 and no redirect: data_hazard=1; npc=pc; flush_idex=1; flush_ifid=0; next state LU_BUBBLE.
REQ-023 LU_BUBBLE: lu_hit is masked for this cycle, so no back-to-back stall occurs for the same pair; data_hazard=0; npc=pc+4; next state RUN.
REQ-024 Otherwise: npc=pc+4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000; all flags 0; next state RUN.
REQ-025 stall_cnt SHALL increment by 1 in every cycle with data_hazard=1.
REQ-026 flush_cnt SHALL increment by 1 in every cycle with flush_ifid=1.
REQ-027 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-028 While rst=1: state RUN; stall_cnt=0; flush_cnt=0; data_hazard=0; both flushes=0; npc=pc+4.
REQ-029 When rst is asserted mid-stall (LU_BUBBLE or MEM_WAIT), the next cycle SHALL be RUN and no pending stall or redirect SHALL be retained.

Verification
REQ-030 pc=0x100 and no hazards for 3 cycles -> npc=0x104 each cycle; flags 0; counters 0.
REQ-031 ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> cycle 0: data_hazard=1, flush_idex=1, npc=pc. Cycle 1, same inputs held: data_hazard=0 (LU_BUBBLE). stall_cnt=1.
REQ-032 Same load-use pattern with ex_rd=0 or id_rs1_used=0 -> no stall.
REQ-033 ex_redirect=1 with ex_target=0x203 together with lu_hit=1 -> npc=0x200; flush_ifid=1; flush_idex=1; data_hazard=0; flush_cnt=1.
REQ-034 mem_busy=1 for 4 cycles with ex_redirect=1 -> data_hazard=1 and npc=pc throughout; on the release cycle npc=target; stall_cnt=4.
REQ-035 Preload the counters to all-ones minus 1, then stall 3 times -> stall_cnt holds at all-ones. Then assert rst in LU_BUBBLE -> counters 0 and state RUN.
